// File: rtl/fpu_normalizer_seq.sv
// Sequential left-normalizer for FPU mantissas. It shifts left one bit per clock
// until the MSB is set or the caller's shift limit is reached.
module fpu_normalizer_seq #(
  parameter int WORD_LENGTH = 8,
  parameter int SHIFT_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_LENGTH-1:0] data_in,
  input  logic [SHIFT_LIMIT-1:0] max_shift,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_LENGTH-1:0] data_out,
  output logic [SHIFT_LIMIT-1:0] shift_count,
  output logic                   zero,
  output logic                   saturated
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state;
  logic [WORD_LENGTH-1:0] work_reg;
  logic [SHIFT_LIMIT-1:0] limit_reg;
  logic [SHIFT_LIMIT-1:0] count_reg;
  logic                   zero_reg;
  logic                   sat_reg;
  logic                   valid_reg;

  logic [WORD_LENGTH-1:0] shifted;
  logic [SHIFT_LIMIT-1:0] count_inc;

  assign shifted   = {work_reg[WORD_LENGTH-2:0], 1'b0};
  assign count_inc = count_reg + SHIFT_LIMIT'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      work_reg  <= '0;
      limit_reg <= '0;
      count_reg <= '0;
      zero_reg  <= 1'b0;
      sat_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work_reg  <= data_in;
            limit_reg <= max_shift;
            count_reg <= '0;
            zero_reg  <= 1'b0;
            sat_reg   <= 1'b0;
            if (data_in == '0) begin
              zero_reg  <= 1'b1;
              valid_reg <= 1'b1;
              state     <= DONE;
            end else if (data_in[WORD_LENGTH-1]) begin
              valid_reg <= 1'b1;
              state     <= DONE;
            end else if (max_shift == '0) begin
              // Already at the underflow guard: report it without shifting.
              sat_reg   <= 1'b1;
              valid_reg <= 1'b1;
              state     <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work_reg  <= shifted;
          count_reg <= count_inc;
          if (shifted[WORD_LENGTH-1]) begin
            valid_reg <= 1'b1;
            state     <= DONE;
          end else if (count_inc == limit_reg) begin
            sat_reg   <= 1'b1;
            valid_reg <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            valid_reg <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          valid_reg <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (state == IDLE) && reset;
  assign out_valid   = valid_reg;
  assign data_out    = work_reg;
  assign shift_count = count_reg;
  assign zero        = zero_reg;
  assign saturated   = sat_reg;

endmodule

// File: tb/tb_fpu_normalizer_seq.sv
// Directed bench for fpu_normalizer_seq with hand-computed expected results.
// Each task drives one scenario and compares its results inline.
module tb_fpu_normalizer_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_in;
  logic [7:0] max_shift;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] data_out;
  logic [7:0] shift_count;
  logic       zero;
  logic       saturated;

  int assertions = 0;
  int failures   = 0;

  fpu_normalizer_seq #(.WORD_LENGTH(8), .SHIFT_LIMIT(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .max_shift(max_shift), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .shift_count(shift_count),
    .zero(zero), .saturated(saturated)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand for a single accept edge (E0).
  task automatic send(input logic [7:0] d, input logic [7:0] m);
    data_in   = d;
    max_shift = m;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  // Count edges after E0 until out_valid, noting whether in_ready was ever high.
  task automatic wait_valid(output int cycles, output bit ready_seen);
    cycles     = 0;
    ready_seen = in_ready;
    while (!out_valid && cycles < 40) begin
      tick();
      cycles++;
      if (!out_valid && in_ready) ready_seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; data_in = 8'h00; max_shift = 8'h00; out_ready = 1'b1;
    tick(); tick();
    assertions++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    assertions++;
    if ({out_valid, data_out, shift_count, zero, saturated} !== 19'h0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b d=%h c=%0d z=%b s=%b want all 0", out_valid, data_out, shift_count, zero, saturated);
    end
    reset = 1'b1;
    tick();
    assertions++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
    $display("test_reset: done");
  endtask

  task automatic test_msb_set();
    int  cyc;
    bit  rs;
    out_ready = 1'b1;
    send(8'h80, 8'd8);
    wait_valid(cyc, rs);
    assertions++;
    if (cyc !== 0) begin failures++; $display("FAIL msb_latency got %0d want 0", cyc); end
    assertions++;
    if ({data_out, shift_count, zero, saturated} !== {8'h80, 8'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL msb_result got d=%h c=%0d z=%b s=%b want d=80 c=0 z=0 s=0", data_out, shift_count, zero, saturated);
    end
    tick();
    assertions++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++; $display("FAIL msb_handshake got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    $display("test_msb_set: d=80 -> d=%h c=%0d", data_out, shift_count);
  endtask

  task automatic test_full_shift();
    int cyc;
    bit rs;
    send(8'h01, 8'd8);
    wait_valid(cyc, rs);
    assertions++;
    if (cyc !== 7) begin failures++; $display("FAIL full_latency got %0d want 7", cyc); end
    assertions++;
    if (rs !== 1'b0) begin failures++; $display("FAIL full_in_ready got high want low during shift"); end
    assertions++;
    if ({data_out, shift_count, zero, saturated} !== {8'h80, 8'd7, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL full_result got d=%h c=%0d z=%b s=%b want d=80 c=7 z=0 s=0", data_out, shift_count, zero, saturated);
    end
    tick();
    $display("test_full_shift: d=01 -> %0d cycles", cyc);
  endtask

  task automatic test_zero();
    int cyc;
    bit rs;
    send(8'h00, 8'd8);
    wait_valid(cyc, rs);
    assertions++;
    if (cyc !== 0) begin failures++; $display("FAIL zero_latency got %0d want 0", cyc); end
    assertions++;
    if ({data_out, shift_count, zero, saturated} !== {8'h00, 8'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL zero_result got d=%h c=%0d z=%b s=%b want d=00 c=0 z=1 s=0", data_out, shift_count, zero, saturated);
    end
    tick();
    $display("test_zero: d=00 z=1");
  endtask

  task automatic test_saturate();
    int cyc;
    bit rs;
    send(8'h05, 8'd2);
    wait_valid(cyc, rs);
    assertions++;
    if (cyc !== 2) begin failures++; $display("FAIL sat2_latency got %0d want 2", cyc); end
    assertions++;
    if ({data_out, shift_count, zero, saturated} !== {8'h14, 8'd2, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL sat2_result got d=%h c=%0d z=%b s=%b want d=14 c=2 z=0 s=1", data_out, shift_count, zero, saturated);
    end
    tick();
    send(8'h05, 8'd0);
    wait_valid(cyc, rs);
    assertions++;
    if (cyc !== 0) begin failures++; $display("FAIL sat0_latency got %0d want 0", cyc); end
    assertions++;
    if ({data_out, shift_count, zero, saturated} !== {8'h05, 8'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL sat0_result got d=%h c=%0d z=%b s=%b want d=05 c=0 z=0 s=1", data_out, shift_count, zero, saturated);
    end
    tick();
    $display("test_saturate: limits 2 and 0 checked");
  endtask

  task automatic test_backpressure();
    int cyc;
    bit rs;
    out_ready = 1'b0;
    send(8'h20, 8'd8);
    wait_valid(cyc, rs);
    assertions++;
    if (cyc !== 2) begin failures++; $display("FAIL bp_latency got %0d want 2", cyc); end
    data_in = 8'hFF; max_shift = 8'd8; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      assertions++;
      if ({out_valid, in_ready, data_out, shift_count} !== {1'b1, 1'b0, 8'h80, 8'd2}) begin
        failures++;
        $display("FAIL bp_hold[%0d] got v=%b r=%b d=%h c=%0d want v=1 r=0 d=80 c=2", i, out_valid, in_ready, data_out, shift_count);
      end
    end
    out_ready = 1'b1;
    tick();
    assertions++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    assertions++;
    if ({out_valid, data_out, shift_count, saturated} !== {1'b1, 8'hFF, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL bp_next got v=%b d=%h c=%0d s=%b want v=1 d=FF c=0 s=0", out_valid, data_out, shift_count, saturated);
    end
    tick();
    $display("test_backpressure: held 5 cycles then accepted FF");
  endtask

  task automatic test_reset_abort();
    int cyc;
    bit rs;
    bit pulsed = 1'b0;
    send(8'h01, 8'd8);
    tick(); tick();
    reset = 1'b0;
    tick();
    assertions++;
    if ({out_valid, in_ready, data_out, shift_count, zero, saturated} !== 20'h0) begin
      failures++;
      $display("FAIL abort_outputs got v=%b r=%b d=%h c=%0d z=%b s=%b want all 0", out_valid, in_ready, data_out, shift_count, zero, saturated);
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 2) reset = 1'b1;
      tick();
      if (out_valid) pulsed = 1'b1;
    end
    assertions++;
    if (pulsed !== 1'b0) begin failures++; $display("FAIL abort_no_result got out_valid pulse want none"); end
    assertions++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got %b want 1", in_ready); end
    send(8'h40, 8'd8);
    wait_valid(cyc, rs);
    assertions++;
    if ({cyc[7:0], data_out, shift_count} !== {8'd1, 8'h80, 8'd1}) begin
      failures++;
      $display("FAIL abort_next got cyc=%0d d=%h c=%0d want cyc=1 d=80 c=1", cyc, data_out, shift_count);
    end
    tick();
    $display("test_reset_abort: aborted then d=40 c=%0d", shift_count);
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit rs;
    send(8'h03, 8'd8);
    wait_valid(cyc, rs);
    assertions++;
    if ({cyc[7:0], data_out, shift_count, saturated} !== {8'd6, 8'hC0, 8'd6, 1'b0}) begin
      failures++;
      $display("FAIL b2b_first got cyc=%0d d=%h c=%0d s=%b want cyc=6 d=C0 c=6 s=0", cyc, data_out, shift_count, saturated);
    end
    tick();
    send(8'h10, 8'd8);
    wait_valid(cyc, rs);
    assertions++;
    if ({cyc[7:0], data_out, shift_count, saturated} !== {8'd3, 8'h80, 8'd3, 1'b0}) begin
      failures++;
      $display("FAIL b2b_second got cyc=%0d d=%h c=%0d s=%b want cyc=3 d=80 c=3 s=0", cyc, data_out, shift_count, saturated);
    end
    tick();
    $display("test_back_to_back: 03 then 10");
  endtask

  initial begin
    test_reset();
    test_msb_set();
    test_full_shift();
    test_zero();
    test_saturate();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
